dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Target side of the CPU DMEM port. Serves the pipeline's MEM-stage loads and stores.
//  Holds a byte-strobed data RAM and a small MMIO window: free-running cycle counter,
//  scratch register, and a TX word FIFO drained by an external valid/ready consumer.
//  Read data is combinational, so loads complete in the same cycle as the MEM stage.
// PARAMETERS
//  RAM_WORDS   1024           data RAM depth in 32-bit words; power of 2
//  FIFO_DEPTH  8              TX FIFO depth in words; power of 2, >=2
//  MMIO_BASE   32'h8000_0000  base of the MMIO window; 16-byte window
// PORTS
//  clk          in   1   clock; all state changes on posedge
//  rst          in   1   synchronous reset, active-high
//  dmem_addr    in   32  byte address from CPU; addr[1:0] ignored (word access)
//  dmem_wrdata  in   32  store data, byte lanes aligned to word
//  dmem_wrstb   in   4   byte write strobes (wrstb_t); 0 = read-only cycle
//  dmem_rddata  out  32  combinational read data for dmem_addr
//  tx_data      out  32  FIFO head word
//  tx_valid     out  1   FIFO non-empty
//  tx_ready     in   1   consumer accepts head when tx_valid & tx_ready
//  bus_err      out  1   one-cycle pulse: previous-cycle store hit unmapped or RO location
// BEHAVIOUR
//  - Addressing: the CPU presents an address every cycle, so reads MUST be side-effect free.
//  - Writes commit at posedge when wrstb!=0. Same-cycle rddata returns the pre-write value.
//  - RAM decode: addr < RAM_WORDS*4. Word index is addr[$clog2(RAM_WORDS)+1:2].
//    Each wrstb[i] writes byte i. RAM contents are not reset.
//  - MMIO decode: addr[31:4]==MMIO_BASE[31:4]. Offsets are given by addr[3:2].
//    0x0 CYCLE      RO  32-bit counter; 0 in first cycle after reset; +1 every cycle; wraps 2^32-1 -> 0
//    0x4 SCRATCH    RW  byte-strobed; reset 0
//    0x8 TX_DATA    WO  wrstb==4'hF pushes wrdata. Partial strobe: no push, bus_err. Reads 0.
//    0xC TX_STATUS  bit0 full, bit1 empty, bit2 overflow (sticky), [15:8] count, others 0.
//                   Write with wrstb[0] & wrdata[2] clears overflow (W1C).
//                   Other written bits are ignored, with no bus_err.
//  - Unmapped: reads return 0 without error. Store -> bus_err. Store to CYCLE -> bus_err, no effect.
//  - bus_err is registered: asserts in the cycle after the offending store, for 1 cycle.
//    Back-to-back offending stores keep it high.
//  - FIFO pop = tx_valid & tx_ready.
//  - FIFO push accepted if !full, or if full and a pop happens in the same cycle.
//    A push that is not accepted is dropped and sets overflow.
//  - Push into an empty FIFO: tx_valid rises next cycle. No fall-through.
//    tx_data is stable while tx_valid & !tx_ready.
//  - Simultaneous push+pop: count unchanged; head advances; new word enters at tail.
//  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. count ranges 0..FIFO_DEPTH.
//  - Reset values: tx_valid 0, bus_err 0, CYCLE 0, SCRATCH 0, FIFO empty, overflow 0.
//    dmem_rddata follows decode immediately.
//  - Reset asserted mid-operation: the FIFO empties and queued words are lost.
//    Stores in the reset cycle are ignored, except RAM writes, which still commit.
// STRUCTURE
//  - Add to the shared types package: mmio_off_e enum (CYCLE, SCRATCH, TX_DATA, TX_STATUS).
//    Also add the status bit index localparams (ST_FULL=0, ST_EMPTY=1, ST_OVF=2, ST_CNT_LSB=8).
//  - Reuse u32_t and wrstb_t.
//  - Sub-module sync_fifo #(WIDTH, DEPTH):
//    push/pop/full/empty/count, head data registered-out.
//  - Top level holds the RAM array, the decode logic, CYCLE/SCRATCH/overflow/bus_err flops,
//    and the read mux.
// TESTING
//  - Reset then store 0xDEADBEEF to 0x10 with wrstb=4'b0101, then load 0x10.
//    Required: 0x00AD00EF, assuming prior contents 0. Same-cycle rddata shows the old value.
//  - Read CYCLE in the first cycle after reset -> 0. Read it 5 cycles later -> 5.
//    Force the counter to 0xFFFFFFFF -> next read 0.
//  - Push 8 words 1..8 with tx_ready=0.
//    Required: STATUS = full=1, count=8. A 9th push is dropped and sets overflow (STATUS bit2=1).
//    W1C 0x4 to STATUS clears it.
//  - With the FIFO full, push 9 and hold tx_ready=1 in the same cycle.
//    Required: word 1 is popped, 9 is accepted, count stays 8, overflow stays 0.
//    Drain order is 2..9.
//  - Store to 0x4000_0000, to CYCLE, and to TX_DATA with wrstb=4'b0011.
//    Required: bus_err pulses 1 cycle after each store and no FIFO push occurs.
//    A load from 0x4000_0000 returns 0 with no bus_err.
//  - Assert rst with 3 words queued.
//    Required next cycle: tx_valid=0, STATUS empty=1 count=0, SCRATCH=0. RAM retains data.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// ============================================================================
// Module   : dmem_responder_pkg
// Brief    : Shared DMEM types, MMIO offset encoding and TX status bit layout.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_responder_pkg;

    typedef logic [31:0] u32_t;
    typedef logic [3:0]  wrstb_t;

    typedef enum logic [1:0] {
        MMIO_CYCLE     = 2'd0,
        MMIO_SCRATCH   = 2'd1,
        MMIO_TX_DATA   = 2'd2,
        MMIO_TX_STATUS = 2'd3
    } mmio_off_e;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO; head word read straight from storage registers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_pop;
    logic               w_push;

    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    // A push into a full FIFO is still taken when a pop frees the head slot.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Brief    : CPU DMEM target: byte-strobed RAM plus CYCLE/SCRATCH/TX FIFO MMIO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int   RAM_WORDS  = 1024,
    parameter int   FIFO_DEPTH = 8,
    parameter u32_t MMIO_BASE  = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wrdata,
    input  logic [3:0]  dmem_wrstb,
    output logic [31:0] dmem_rddata,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_err
);

    localparam int   c_IDX_W     = $clog2(RAM_WORDS);
    localparam int   c_CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam u32_t c_RAM_BYTES = u32_t'(RAM_WORDS * 4);

    u32_t               r_ram [RAM_WORDS];
    u32_t               r_cycle;
    u32_t               r_scratch;
    logic               r_ovf;
    logic               r_bus_err;

    logic               w_ram_hit;
    logic               w_mmio_hit;
    mmio_off_e          w_off;
    logic [c_IDX_W-1:0] w_ram_idx;
    logic               w_store;
    logic               w_push_req;
    logic               w_pop;
    logic               w_ovf_clr;
    logic               w_bad_store;
    logic               w_full;
    logic               w_empty;
    logic [c_CNT_W-1:0] w_count;
    u32_t               w_status;
    wrstb_t             w_stb;

    assign w_stb      = dmem_wrstb;
    assign w_ram_hit  = (dmem_addr < c_RAM_BYTES);
    assign w_mmio_hit = (dmem_addr[31:4] == MMIO_BASE[31:4]);
    assign w_off      = mmio_off_e'(dmem_addr[3:2]);
    assign w_ram_idx  = dmem_addr[c_IDX_W+1:2];
    assign w_store    = |w_stb;

    assign w_push_req = w_store & w_mmio_hit & (w_off == MMIO_TX_DATA) & (w_stb == 4'hF);
    assign w_pop      = tx_valid & tx_ready;
    assign w_ovf_clr  = w_store & w_mmio_hit & (w_off == MMIO_TX_STATUS)
                      & w_stb[0] & dmem_wrdata[ST_OVF];

    // Unmapped stores, CYCLE stores and partial TX_DATA stores are all errors.
    assign w_bad_store = w_store & ((~w_ram_hit & ~w_mmio_hit)
                       | (w_mmio_hit & (w_off == MMIO_CYCLE))
                       | (w_mmio_hit & (w_off == MMIO_TX_DATA) & (w_stb != 4'hF)));

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push_req & ~rst),
        .pop       (w_pop),
        .push_data (dmem_wrdata),
        .head_data (tx_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign tx_valid = ~w_empty;
    assign bus_err  = r_bus_err;

    // RAM has no reset and keeps accepting writes while rst is high.
    always_ff @(posedge clk) begin
        if (w_store && w_ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_stb[i]) r_ram[w_ram_idx][8*i +: 8] <= dmem_wrdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle   <= '0;
            r_scratch <= '0;
            r_ovf     <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_cycle   <= r_cycle + 32'd1;
            r_bus_err <= w_bad_store;
            if (w_store && w_mmio_hit && (w_off == MMIO_SCRATCH)) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_stb[i]) r_scratch[8*i +: 8] <= dmem_wrdata[8*i +: 8];
                end
            end
            if (w_push_req && w_full && !w_pop) r_ovf <= 1'b1;
            else if (w_ovf_clr)                 r_ovf <= 1'b0;
        end
    end

    always_comb begin
        w_status                    = '0;
        w_status[ST_FULL]           = w_full;
        w_status[ST_EMPTY]          = w_empty;
        w_status[ST_OVF]            = r_ovf;
        w_status[ST_CNT_LSB +: 8]   = 8'(w_count);
    end

    always_comb begin
        dmem_rddata = '0;
        if (w_ram_hit) begin
            dmem_rddata = r_ram[w_ram_idx];
        end else if (w_mmio_hit) begin
            case (w_off)
                MMIO_CYCLE:     dmem_rddata = r_cycle;
                MMIO_SCRATCH:   dmem_rddata = r_scratch;
                MMIO_TX_STATUS: dmem_rddata = w_status;
                default:        dmem_rddata = '0;
            endcase
        end
    end

endmodule

`default_nettype wire
